// File: rtl/lcd_refresh_arb.sv
// lcd_refresh_arb: two-requester character-memory write arbiter
// plus refresh launcher with holdoff and busy-timeout for an LCD driver.

module lcd_refresh_arb #(
    parameter int REFRESH_MIN  = 2500,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [1:0] a_row,
    input  logic [3:0] a_col,
    input  logic [7:0] a_char,
    output logic       a_gnt,
    input  logic       b_req,
    input  logic [1:0] b_row,
    input  logic [3:0] b_col,
    input  logic [7:0] b_char,
    output logic       b_gnt,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       trg,
    input  logic       busy,
    input  logic       frc,
    output logic       pend,
    output logic       err
);

    localparam int HW =
        (REFRESH_MIN > 1) ? $clog2(REFRESH_MIN) : 1;
    localparam int TW =
        (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LOAD =
        HW'(REFRESH_MIN - 1);
    localparam logic [TW-1:0] TMO_LAST =
        TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_BUSY,
        WAIT_DONE,
        HOLDOFF
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nx;
    logic          dirty;
    logic          dirty_nx;
    logic          err_nx;
    logic          last_b;
    logic          win;
    logic          ga;
    logic          gb;
    logic          gany;

    // Write window and round-robin pick of one requester
    always_comb begin
        win = ((state == IDLE) || (state == HOLDOFF)) && !busy;
        ga  = 1'b0;
        gb  = 1'b0;
        if (win) begin
            if (a_req && b_req) begin
                ga = last_b;
                gb = !last_b;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
        gany = ga | gb;
    end

    // Refresh sequencing: next state, counters, dirty/err, trg
    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        tcnt_nx  = tcnt;
        dirty_nx = dirty | gany | frc;
        err_nx   = err;
        trg      = 1'b0;
        case (state)
            IDLE: begin
                if (dirty && !busy && !gany) begin
                    state_nx = TRIG;
                end
            end
            TRIG: begin
                trg      = 1'b1;
                dirty_nx = frc;
                tcnt_nx  = '0;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_nx = WAIT_DONE;
                end else if (tcnt == TMO_LAST) begin
                    err_nx   = 1'b1;
                    dirty_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    hcnt_nx  = HOLD_LOAD;
                    state_nx = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hcnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    hcnt_nx = hcnt - HW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Controller state, counters, flags and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hcnt   <= '0;
            tcnt   <= '0;
            dirty  <= 1'b0;
            err    <= 1'b0;
            last_b <= 1'b1;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
            tcnt  <= tcnt_nx;
            dirty <= dirty_nx;
            err   <= err_nx;
            if (gany) begin
                last_b <= gb;
            end
        end
    end

    // Registered one-cycle grant and memory write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            a_gnt <= ga;
            b_gnt <= gb;
            wr_en <= gany;
            if (gb) begin
                wr_addr <= {b_row, b_col};
                wr_data <= b_char;
            end else if (ga) begin
                wr_addr <= {a_row, a_col};
                wr_data <= a_char;
            end else begin
                wr_addr <= '0;
                wr_data <= '0;
            end
        end
    end

    assign pend = dirty;

endmodule

// File: tb/tb_lcd_refresh_arb.sv
// tb_lcd_refresh_arb: directed scenarios plus randomized traffic
// checked cycle by cycle against a timestamp-based reference model.

module tb_lcd_refresh_arb;

    localparam int R  = 32;
    localparam int BT = 8;

    logic       clk;
    logic       rst;
    logic       a_req;
    logic [1:0] a_row;
    logic [3:0] a_col;
    logic [7:0] a_char;
    logic       a_gnt;
    logic       b_req;
    logic [1:0] b_row;
    logic [3:0] b_col;
    logic [7:0] b_char;
    logic       b_gnt;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       trg;
    logic       busy;
    logic       frc;
    logic       pend;
    logic       err;

    lcd_refresh_arb #(
        .REFRESH_MIN (R),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a_req  (a_req),
        .a_row  (a_row),
        .a_col  (a_col),
        .a_char (a_char),
        .a_gnt  (a_gnt),
        .b_req  (b_req),
        .b_row  (b_row),
        .b_col  (b_col),
        .b_char (b_char),
        .b_gnt  (b_gnt),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .trg    (trg),
        .busy   (busy),
        .frc    (frc),
        .pend   (pend),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk;
    int nfail;
    int cyc;

    // reference model: refresh tracked as "launching", "in flight"
    // and the earliest cycle a new launch may be decided
    logic m_dirty;
    logic m_err;
    logic m_launch;
    logic m_infl;
    logic m_seen;
    logic m_last_b;
    int   m_t;
    int   m_ready;

    logic       e_agnt;
    logic       e_bgnt;
    logic       e_wren;
    logic [5:0] e_addr;
    logic [7:0] e_data;

    // fake LCD driver
    logic drv_en;
    logic drv_ignore;
    int   drv_dly;
    int   drv_len;
    int   drv_rise;
    int   drv_fall;
    logic auto_drop;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dirty  = 1'b0;
        m_err    = 1'b0;
        m_launch = 1'b0;
        m_infl   = 1'b0;
        m_seen   = 1'b0;
        m_last_b = 1'b1;
        m_t      = 0;
        m_ready  = 0;
        cyc      = 0;
        drv_rise = 0;
        drv_fall = 0;
    endtask

    task automatic tick();
        logic win;
        logic ga;
        logic gb;
        logic g;
        logic nl;
        win = !m_launch && !m_infl && !busy;
        ga  = 1'b0;
        gb  = 1'b0;
        if (win) begin
            if (a_req && b_req) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
        g      = ga | gb;
        e_agnt = ga;
        e_bgnt = gb;
        e_wren = g;
        e_addr = gb ? {b_row, b_col} : {a_row, a_col};
        e_data = gb ? b_char : a_char;
        if (g) m_last_b = gb;
        nl = 1'b0;
        if (m_launch) begin
            m_dirty = frc;
            m_infl  = 1'b1;
            m_seen  = 1'b0;
            m_t     = 1;
        end else if (m_infl) begin
            if (m_seen) begin
                if (!busy) begin
                    m_infl  = 1'b0;
                    m_ready = cyc + R + 1;
                end
            end else if (busy) begin
                m_seen = 1'b1;
            end else if (m_t == BT) begin
                m_err   = 1'b1;
                m_dirty = 1'b1;
                m_infl  = 1'b0;
                m_ready = cyc + 1;
            end else begin
                m_t++;
            end
            m_dirty = m_dirty | frc;
        end else begin
            nl = m_dirty && !busy && !g && (cyc >= m_ready);
            m_dirty = m_dirty | g | frc;
        end
        m_launch = nl;
        @(posedge clk);
        #1;
        cyc++;
        chk("trg", 32'(trg), 32'(m_launch));
        chk("a_gnt", 32'(a_gnt), 32'(e_agnt));
        chk("b_gnt", 32'(b_gnt), 32'(e_bgnt));
        chk("wr_en", 32'(wr_en), 32'(e_wren));
        chk("pend", 32'(pend), 32'(m_dirty));
        chk("err", 32'(err), 32'(m_err));
        if (e_wren) begin
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
        frc = 1'b0;
        if (auto_drop) begin
            if (e_agnt) a_req = 1'b0;
            if (e_bgnt) b_req = 1'b0;
        end
        if (drv_en) begin
            if (m_launch && !drv_ignore) begin
                drv_rise = cyc + drv_dly;
                drv_fall = drv_rise + drv_len;
            end
            busy = (cyc >= drv_rise) && (cyc < drv_fall);
        end
    endtask

    task automatic do_reset(input logic bz);
        #2;
        rst   = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        frc   = 1'b0;
        busy  = bz;
        #1;
        chk("rst_trg", 32'(trg), 32'd0);
        chk("rst_a_gnt", 32'(a_gnt), 32'd0);
        chk("rst_b_gnt", 32'(b_gnt), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic wait_trg(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (trg === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    int c;
    int t;
    int g;
    int fb;
    int cnt;

    initial begin
        nchk       = 0;
        nfail      = 0;
        rst        = 1'b0;
        a_req      = 1'b0;
        b_req      = 1'b0;
        a_row      = '0;
        a_col      = '0;
        a_char     = '0;
        b_row      = '0;
        b_col      = '0;
        b_char     = '0;
        busy       = 1'b0;
        frc        = 1'b0;
        drv_en     = 1'b0;
        drv_ignore = 1'b0;
        drv_dly    = 2;
        drv_len    = 10;
        auto_drop  = 1'b1;
        model_reset();

        // write held off by driver init, granted once busy falls
        do_reset(1'b1);
        a_row  = 2'd2;
        a_col  = 4'd5;
        a_char = 8'h41;
        a_req  = 1'b1;
        cnt = 0;
        repeat (100) begin
            tick();
            if (a_gnt || b_gnt) cnt++;
        end
        chk("init_no_gnt", cnt, 0);
        c = cyc;
        busy = 1'b0;
        tick();
        chk("init_gnt", 32'(a_gnt), 32'd1);
        chk("init_addr", 32'(wr_addr), 32'h25);
        chk("init_data", 32'(wr_data), 32'h41);
        chk("init_pend", 32'(pend), 32'd1);
        drv_en = 1'b1;
        wait_trg(5, t);
        chk("init_trg_cyc", t, c + 2);
        chk("init_trg_pend", 32'(pend), 32'd1);
        tick();
        chk("init_pend_clr", 32'(pend), 32'd0);
        cnt = 0;
        repeat (R + 40) begin
            tick();
            if (trg) cnt++;
        end
        chk("init_single_trg", cnt, 0);

        // tie held four cycles: A, B, A, B
        do_reset(1'b0);
        a_row  = 2'd0;
        a_col  = 4'd1;
        a_char = 8'h10;
        b_row  = 2'd3;
        b_col  = 4'hc;
        b_char = 8'h20;
        auto_drop = 1'b0;
        a_req = 1'b1;
        b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_a", 32'(a_gnt), 32'(k % 2 == 0));
            chk("rr_b", 32'(b_gnt), 32'(k % 2 == 1));
            chk("rr_wr_en", 32'(wr_en), 32'd1);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        auto_drop = 1'b1;
        c = cyc;
        wait_trg(5, t);
        chk("rr_trg_cyc", t, c + 1);
        repeat (R + 40) tick();

        // long refresh with a write attempted mid-refresh
        drv_dly = 2;
        drv_len = 50;
        c = cyc;
        frc = 1'b1;
        wait_trg(5, t);
        chk("long_trg_cyc", t, c + 2);
        fb = drv_fall;
        drv_len = 10;
        repeat (20) tick();
        a_row  = 2'd1;
        a_col  = 4'hf;
        a_char = 8'h7e;
        a_req  = 1'b1;
        g = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (a_gnt === 1'b1) begin
                g = cyc;
                break;
            end
        end
        // busy first low at fb (still WAIT_DONE), window opens at fb+1
        chk("long_gnt_cyc", g, fb + 2);
        wait_trg(R + 10, t);
        // fb: WAIT_DONE, R holdoff cycles, one IDLE launch cycle
        chk("holdoff_trg_cyc", t, fb + R + 2);
        repeat (R + 40) tick();

        // driver never answers: timeout, err, re-trigger
        drv_ignore = 1'b1;
        frc = 1'b1;
        wait_trg(5, t);
        repeat (BT) tick();
        chk("tmo_err_early", 32'(err), 32'd0);
        tick();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_pend", 32'(pend), 32'd1);
        chk("tmo_idle", 32'(trg), 32'd0);
        drv_ignore = 1'b0;
        tick();
        chk("tmo_retrg", 32'(trg), 32'd1);
        chk("tmo_retrg_cyc", cyc, t + BT + 2);
        repeat (R + 40) tick();

        // reset in WAIT_DONE with pend and err both set
        drv_len = 30;
        frc = 1'b1;
        wait_trg(5, t);
        repeat (5) tick();
        frc = 1'b1;
        tick();
        chk("wd_pend", 32'(pend), 32'd1);
        repeat (4) tick();
        chk("wd_err", 32'(err), 32'd1);
        do_reset(1'b0);
        cnt = 0;
        repeat (60) begin
            tick();
            if (trg) cnt++;
        end
        chk("rst_no_trg", cnt, 0);
        c = cyc;
        frc = 1'b1;
        wait_trg(5, t);
        chk("rst_frc_trg_cyc", t, c + 2);
        repeat (R + 40) tick();

        // grant and launch eligible together: grant first
        drv_en = 1'b0;
        do_reset(1'b1);
        frc = 1'b1;
        tick();
        a_row  = 2'd0;
        a_col  = 4'd0;
        a_char = 8'h55;
        a_req  = 1'b1;
        repeat (3) tick();
        chk("tie_pend", 32'(pend), 32'd1);
        busy = 1'b0;
        drv_en = 1'b1;
        tick();
        chk("tie_gnt", 32'(a_gnt), 32'd1);
        chk("tie_no_trg", 32'(trg), 32'd0);
        tick();
        chk("tie_trg", 32'(trg), 32'd1);
        chk("tie_gnt_off", 32'(a_gnt), 32'd0);
        repeat (R + 40) tick();

        // randomized traffic against the model
        do_reset(1'b0);
        repeat (3000) begin
            if (!a_req && ($urandom_range(0, 3) == 0)) begin
                a_row  = 2'($urandom);
                a_col  = 4'($urandom);
                a_char = 8'($urandom);
                a_req  = 1'b1;
            end
            if (!b_req && ($urandom_range(0, 3) == 0)) begin
                b_row  = 2'($urandom);
                b_col  = 4'($urandom);
                b_char = 8'($urandom);
                b_req  = 1'b1;
            end
            frc        = ($urandom_range(0, 19) == 0);
            drv_dly    = int'($urandom_range(1, 3));
            drv_len    = int'($urandom_range(2, 20));
            drv_ignore = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
